// File: rtl/rvsteel_button_pkg.sv
// Shared types and elaboration helpers for the rvsteel button conditioner.
// Holds the debounce channel state encoding and the functions that derive the
// debounce cycle count and counter width from the clock frequency and the
// required stable time.
package rvsteel_button_pkg;

    // Debounce channel states: STABLE while the synchronised input matches the
    // debounced level, CHANGING while a candidate new level is being timed.
    typedef enum logic {
        STABLE   = 1'b0,
        CHANGING = 1'b1
    } debounce_state_e;

    // Number of clock cycles the synchronised input must differ from the
    // current level before the level flips.
    function automatic int debounce_cycles(input int clock_frequency,
                                           input int debounce_time_us);
        return clock_frequency / 1000000 * debounce_time_us;
    endfunction

    // Width of a counter that can hold 0..cycles without wrapping.
    function automatic int debounce_counter_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/rvsteel_debounce_channel.sv
// One button channel: 2-flop synchroniser, cycle-counted stability filter and
// rising-edge press detector. The filter FSM is STABLE/CHANGING; a change is
// accepted only after the synchronised input has differed from the level on
// DEBOUNCE_CYCLES consecutive edges, and any bounce back restarts the timing.
module rvsteel_debounce_channel
    import rvsteel_button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic level,
    output logic pressed
);

    localparam int                CNT_W     = debounce_counter_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_STEP  = CNT_W'(1);

    logic             sync_meta;
    logic             sync;
    debounce_state_e  state;
    debounce_state_e  state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             level_next;
    logic             level_d;

    // State register: synchroniser, FSM state, counter and level history.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
            state     <= STABLE;
            count     <= '0;
            level     <= 1'b0;
            level_d   <= 1'b0;
        end else begin
            sync_meta <= button;
            sync      <= sync_meta;
            state     <= state_next;
            count     <= count_next;
            level     <= level_next;
            level_d   <= level;
        end
    end

    // Next-state logic: the entry edge counts as the first differing cycle, so
    // the level flips on the DEBOUNCE_CYCLES-th consecutive differing edge.
    always_comb begin
        state_next = state;
        count_next = count;
        level_next = level;
        case (state)
            STABLE: begin
                count_next = '0;
                if (sync != level) begin
                    if (CNT_LAST == '0) begin
                        // A single differing cycle is already enough.
                        level_next = sync;
                    end else begin
                        state_next = CHANGING;
                        count_next = CNT_STEP;
                    end
                end
            end
            CHANGING: begin
                if (sync == level) begin
                    // Bounce: discard the candidate change.
                    state_next = STABLE;
                    count_next = '0;
                end else if (count == CNT_LAST) begin
                    level_next = sync;
                    state_next = STABLE;
                    count_next = '0;
                end else begin
                    count_next = count + CNT_STEP;
                end
            end
        endcase
    end

    // Output logic: one-cycle pulse on a debounced rising edge only.
    always_comb begin
        pressed = level & ~level_d;
    end

endmodule

// File: rtl/rvsteel_button_conditioner.sv
// Board-level button conditioner feeding rvsteel_mcu reset/halt.
// Two independent debounce channels (reset and halt buttons), a reset
// stretcher that keeps mcu_reset asserted for RESET_HOLD_CYCLES edges after the
// debounced reset level drops (and after block reset), and the halt output.
// Optional feature macro: BUTTON_CONDITIONER_HALT_TOGGLE_EN -- when defined,
// mcu_halt toggles on each halt press; otherwise it follows the held button.
module rvsteel_button_conditioner
    import rvsteel_button_pkg::*;
#(
    parameter int CLOCK_FREQUENCY   = 12000000,
    parameter int DEBOUNCE_TIME_US  = 10000,
    parameter int RESET_HOLD_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic reset_button,
    input  logic halt_button,
    output logic mcu_reset,
    output logic mcu_halt,
    output logic reset_pressed,
    output logic halt_pressed
);

    localparam int                DEBOUNCE_CYCLES = debounce_cycles(CLOCK_FREQUENCY, DEBOUNCE_TIME_US);
    localparam int                HOLD_W          = $clog2(RESET_HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD       = HOLD_W'(RESET_HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_STEP       = HOLD_W'(1);

    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
            $error("rvsteel_button_conditioner: DEBOUNCE_CYCLES must be at least 1");
        end
        if (RESET_HOLD_CYCLES < 1) begin : g_bad_hold
            $error("rvsteel_button_conditioner: RESET_HOLD_CYCLES must be at least 1");
        end
    endgenerate

    logic              reset_level;
    logic              halt_level;
    logic [HOLD_W-1:0] hold_count;

    rvsteel_debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_reset_channel (
        .clock   (clock),
        .reset   (reset),
        .button  (reset_button),
        .level   (reset_level),
        .pressed (reset_pressed)
    );

    rvsteel_debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_halt_channel (
        .clock   (clock),
        .reset   (reset),
        .button  (halt_button),
        .level   (halt_level),
        .pressed (halt_pressed)
    );

    // Reset stretcher: reload while the button is held, then count down to 0.
    // Block reset preloads it so the MCU sees a full-width reset at power-up.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_count <= HOLD_LOAD;
        end else if (reset_level) begin
            hold_count <= HOLD_LOAD;
        end else if (hold_count != '0) begin
            hold_count <= hold_count - HOLD_STEP;
        end
    end

    assign mcu_reset = reset_level | (hold_count != '0);

`ifdef BUTTON_CONDITIONER_HALT_TOGGLE_EN
    logic halt_state;

    // Halt toggle: each debounced press flips between running and halted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            halt_state <= 1'b0;
        end else if (halt_pressed) begin
            halt_state <= ~halt_state;
        end
    end

    assign mcu_halt = halt_state;
`else
    assign mcu_halt = halt_level;
`endif

endmodule

// File: tb/tb_rvsteel_button_conditioner.sv
// Self-checking bench for rvsteel_button_conditioner.
// Parameters: 1 MHz clock, 8 us debounce (8 cycles), 4-cycle reset hold.
// Directed vectors carry expectations derived from the timing rules; the random
// phase compares against a sample-history reference model.
module tb_rvsteel_button_conditioner;

    localparam int D   = 8;
    localparam int RHC = 4;
`ifdef BUTTON_CONDITIONER_HALT_TOGGLE_EN
    localparam bit TOGGLE = 1'b1;
`else
    localparam bit TOGGLE = 1'b0;
`endif

    logic clock;
    logic reset;
    logic reset_button;
    logic halt_button;
    logic mcu_reset;
    logic mcu_halt;
    logic reset_pressed;
    logic halt_pressed;

    rvsteel_button_conditioner #(
        .CLOCK_FREQUENCY   (1000000),
        .DEBOUNCE_TIME_US  (8),
        .RESET_HOLD_CYCLES (RHC)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .reset_button  (reset_button),
        .halt_button   (halt_button),
        .mcu_reset     (mcu_reset),
        .mcu_halt      (mcu_halt),
        .reset_pressed (reset_pressed),
        .halt_pressed  (halt_pressed)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic rb;
        logic hb;
        logic er;
        logic eh;
        logic erp;
        logic ehp;
    } vec_t;

    vec_t vecs[$];
    logic tog_track;

    // Reference model: raw samples per edge, newest first.
    bit hist_r[$];
    bit hist_h[$];
    bit m_lr, m_lh, m_rp, m_hp, m_tog;
    int m_since;

    task automatic model_reset();
        hist_r.delete();
        hist_h.delete();
        for (int i = 0; i < D + 2; i++) begin
            hist_r.push_back(1'b0);
            hist_h.push_back(1'b0);
        end
        m_lr = 0; m_lh = 0; m_rp = 0; m_hp = 0; m_tog = 0;
        m_since = 0;
    endtask

    // A level flips when the raw samples taken 2..D+1 edges ago all differ from it.
    task automatic model_edge(input bit rb, input bit hb);
        bit all_r, all_h, nr, nh;
        if (TOGGLE && m_hp) m_tog = ~m_tog;
        if (m_lr) m_since = 0;
        else if (m_since < RHC) m_since++;
        hist_r.push_front(rb); void'(hist_r.pop_back());
        hist_h.push_front(hb); void'(hist_h.pop_back());
        all_r = 1; all_h = 1;
        for (int k = 2; k <= D + 1; k++) begin
            if (hist_r[k] == m_lr) all_r = 0;
            if (hist_h[k] == m_lh) all_h = 0;
        end
        nr = all_r ? ~m_lr : m_lr;
        nh = all_h ? ~m_lh : m_lh;
        m_rp = nr & ~m_lr;
        m_hp = nh & ~m_lh;
        m_lr = nr;
        m_lh = nh;
    endtask

    task automatic check(input string name, input logic actual, input logic expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Driver: apply inputs at the falling edge, advance one rising edge, land on
    // the next falling edge for sampling.
    task automatic step(input logic rb, input logic hb);
        reset_button = rb;
        halt_button  = hb;
        @(posedge clock);
        if (reset) model_edge(rb, hb);
        @(negedge clock);
    endtask

    task automatic add(input logic rb, input logic hb, input logic er,
                       input logic eh, input logic erp, input logic ehp);
        vec_t v;
        v.rb = rb; v.hb = hb; v.er = er; v.eh = eh; v.erp = erp; v.ehp = ehp;
        vecs.push_back(v);
    endtask

    task automatic run_table(input int first, input int last);
        logic eh;
        for (int i = first; i < last; i++) begin
            step(vecs[i].rb, vecs[i].hb);
            eh = TOGGLE ? tog_track : vecs[i].eh;
            check($sformatf("vec%0d.mcu_reset", i), mcu_reset, vecs[i].er);
            check($sformatf("vec%0d.mcu_halt", i), mcu_halt, eh);
            check($sformatf("vec%0d.reset_pressed", i), reset_pressed, vecs[i].erp);
            check($sformatf("vec%0d.halt_pressed", i), halt_pressed, vecs[i].ehp);
            if (vecs[i].ehp) tog_track = ~tog_track;
        end
    endtask

    int a_end, b_end, c_end, d_end, e_end;
    int run_r, run_h;
    logic rb_v, hb_v;

    initial begin
        reset        = 1'b0;
        reset_button = 1'b0;
        halt_button  = 1'b0;
        tog_track    = 1'b0;
        model_reset();

        // A: release block reset with idle buttons; hold lasts 4 edges.
        for (int k = 1; k <= 8; k++) add(0, 0, k < 4, 0, 0, 0);
        a_end = vecs.size();
        // B: clean halt press, level rises 10 edges later, then release.
        for (int k = 1; k <= 14; k++) add(0, 1, 0, k >= 10, 0, k == 10);
        for (int k = 1; k <= 12; k++) add(0, 0, 0, k < 10, 0, 0);
        b_end = vecs.size();
        // C: 7 high, 1 low, 20 high: only the final rise counts.
        for (int k = 1; k <= 28; k++) add(0, (k != 8), 0, k >= 18, 0, k == 18);
        for (int k = 1; k <= 12; k++) add(0, 0, 0, k < 10, 0, 0);
        c_end = vecs.size();
        // D: reset button held 30 cycles; mcu_reset from edge 10 until edge 44.
        for (int k = 1; k <= 50; k++)
            add(k <= 30, 0, (k >= 10 && k <= 43), 0, k == 10, 0);
        d_end = vecs.size();
        // E: both buttons held 12 cycles together.
        for (int k = 1; k <= 28; k++)
            add(k <= 12, k <= 12, (k >= 10 && k <= 25), (k >= 10 && k <= 21), k == 10, k == 10);
        e_end = vecs.size();

        repeat (3) @(negedge clock);
        check("rst.mcu_reset", mcu_reset, 1'b1);
        check("rst.mcu_halt", mcu_halt, 1'b0);
        check("rst.reset_pressed", reset_pressed, 1'b0);
        check("rst.halt_pressed", halt_pressed, 1'b0);
        reset = 1'b1;

        run_table(0, a_end);
        run_table(a_end, b_end);
        run_table(b_end, c_end);
        run_table(c_end, d_end);

        // F: block reset in the middle of a pending halt debounce.
        for (int k = 1; k <= 5; k++) begin
            step(0, 1);
            check($sformatf("f_pre%0d.mcu_halt", k), mcu_halt, tog_track);
            check($sformatf("f_pre%0d.mcu_reset", k), mcu_reset, 1'b0);
        end
        reset = 1'b0;
        model_reset();
        tog_track = 1'b0;
        #1;
        check("f_async.mcu_reset", mcu_reset, 1'b1);
        check("f_async.mcu_halt", mcu_halt, 1'b0);
        check("f_async.reset_pressed", reset_pressed, 1'b0);
        check("f_async.halt_pressed", halt_pressed, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step(0, 1);
            check($sformatf("f_in%0d.mcu_reset", k), mcu_reset, 1'b1);
            check($sformatf("f_in%0d.mcu_halt", k), mcu_halt, 1'b0);
        end
        reset = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step(0, 0);
            check($sformatf("f_post%0d.mcu_reset", k), mcu_reset, k < 4);
            check($sformatf("f_post%0d.mcu_halt", k), mcu_halt, 1'b0);
            check($sformatf("f_post%0d.halt_pressed", k), halt_pressed, 1'b0);
        end

        run_table(d_end, e_end);

        // Random phase against the reference model.
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        run_r = 0; run_h = 0; rb_v = 0; hb_v = 0;
        for (int c = 0; c < 800; c++) begin
            if (run_r == 0) begin
                rb_v  = 1'($urandom_range(0, 1));
                run_r = $urandom_range(1, 20);
            end
            if (run_h == 0) begin
                hb_v  = 1'($urandom_range(0, 1));
                run_h = $urandom_range(1, 20);
            end
            run_r--;
            run_h--;
            step(rb_v, hb_v);
            check($sformatf("rnd%0d.mcu_reset", c), mcu_reset, m_lr | (m_since < RHC));
            check($sformatf("rnd%0d.mcu_halt", c), mcu_halt, TOGGLE ? m_tog : m_lh);
            check($sformatf("rnd%0d.reset_pressed", c), reset_pressed, m_rp);
            check($sformatf("rnd%0d.halt_pressed", c), halt_pressed, m_hp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rvsteel_button_conditioner.md
# rvsteel_button_conditioner

Conditions the raw push-button inputs of an FPGA board before they reach `rvsteel_mcu`. It synchronises each button, debounces it with a cycle-counted stability filter, and stretches the MCU reset to a guaranteed minimum width. It emits one-cycle press pulses for board logic. It sits directly upstream of the `rvsteel_mcu` `reset`/`halt` inputs in every board top.

## Interface
- `CLOCK_FREQUENCY`, 12000000: clock frequency in Hz.
- `DEBOUNCE_TIME_US`, 10000: required stable time in µs. DEBOUNCE_CYCLES = CLOCK_FREQUENCY/1000000*DEBOUNCE_TIME_US; must be ≥1 (elaboration error otherwise).
- `RESET_HOLD_CYCLES`, 16: minimum mcu_reset width after release, ≥1.
- `clock`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low block reset.
- `reset_button`  in  1  raw reset button, active-high, asynchronous to `clock`.
- `halt_button`  in  1  raw halt button, active-high, asynchronous.
- `mcu_reset`  out  1  stretched active-high reset to `rvsteel_mcu.reset`.
- `mcu_halt`  out  1  debounced halt to `rvsteel_mcu.halt`.
- `reset_pressed`  out  1  one-cycle pulse on debounced reset-button rising edge.
- `halt_pressed`  out  1  one-cycle pulse on debounced halt-button rising edge.

## Operation
- Each button passes through: 2-flop synchroniser, debounce channel, edge detector.
- Channel FSM with two states. STABLE: counter=0, while sync==level. CHANGING: entered when sync!=level; counter increments each cycle.
- In CHANGING, if sync returns equal to level (bounce), the channel returns to STABLE and the counter clears on that edge.
- In CHANGING, when counter==DEBOUNCE_CYCLES-1 and sync still differs, `level` flips and the FSM returns to STABLE with counter=0.
- Counter width = clog2(DEBOUNCE_CYCLES+1). It never wraps.
- Press pulse = level & ~level_d. Releases produce no pulse.
- Reset stretcher: hold counter loads RESET_HOLD_CYCLES while the debounced reset level is 1. Otherwise it decrements to 0 and saturates.
- `mcu_reset` = 1 while the hold counter is non-zero or the debounced reset level is 1.
- A press during the hold period reloads the counter. It never shortens the reset.
- Block reset (`reset`=0) asynchronously sets:
  - synchronisers, levels, counters and FSM to 0/STABLE;
  - hold counter to RESET_HOLD_CYCLES;
  - `mcu_reset`=1, `mcu_halt`=0, both pulse outputs=0.
- Block reset mid-debounce discards the pending change.
- Both channels are independent. Simultaneous presses are each handled fully.

## Timing
- Raw change to debounced level change: 2 (synchroniser) + DEBOUNCE_CYCLES cycles, given no bounce.
- Press pulse asserts in the same cycle the level goes high. The pulse lasts exactly 1 cycle.
- `mcu_halt` follows the debounced halt level with 0 extra cycles.
- After `reset` deasserts with the button idle, `mcu_reset` stays 1 for exactly RESET_HOLD_CYCLES rising edges, then falls.
- After the debounced reset level falls, `mcu_reset` falls RESET_HOLD_CYCLES cycles later.
- Reset deassertion is synchronous in effect: all outputs change only on `clock` edges after `reset` rises.

## Configuration
- `BUTTON_CONDITIONER_HALT_TOGGLE_EN` defined:
  - `mcu_halt` is a register toggled by each `halt_pressed` pulse, so press to halt and press again to resume;
  - the register resets to 0.
- Not defined: `mcu_halt` equals the debounced halt level, i.e. halted only while the button is held.

## Structure
- Shared package `rvsteel_button_pkg`:
  - debounce FSM state enum (STABLE, CHANGING);
  - function computing DEBOUNCE_CYCLES and counter width from CLOCK_FREQUENCY/DEBOUNCE_TIME_US.
- Sub-module `rvsteel_debounce_channel` (synchroniser + FSM + counter + edge detect) is instantiated twice.
- The top contains the reset stretcher and the halt-toggle option.

## Test plan
Bench parameters: CLOCK_FREQUENCY=1000000, DEBOUNCE_TIME_US=8 (DEBOUNCE_CYCLES=8), RESET_HOLD_CYCLES=4.
- Release `reset` with buttons idle -> `mcu_reset`=1 for 4 edges then 0. `mcu_halt`=0 and no pulses.
- `halt_button` steps 0→1 and holds -> `mcu_halt` rises exactly 10 cycles later. `halt_pressed` is high for 1 cycle at that edge.
- `halt_button` high 7 cycles, low 1 cycle, high 20 cycles -> no change until 10 cycles after the final rise.
- `reset_button` pressed 30 cycles then released -> `mcu_reset`=1 from press+10 until release+10+4, with one `reset_pressed` pulse.
- Assert `reset` at cycle 5 of a pending halt debounce -> all outputs return to reset values immediately. No `mcu_halt` rise after release.
- With `BUTTON_CONDITIONER_HALT_TOGGLE_EN`: two clean presses -> `mcu_halt` goes 1 after the first and 0 after the second.
